// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: widths, the NOP
// encoding shown to decode when nothing is valid, and the fetch ring entry.
package fetch_queue_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            done;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: issues PCs to imem over req/gnt, buffers up to
// DEPTH in-flight/returned fetches in a ring, and drops stale responses after a flush.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = fetch_queue_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic            pc_valid_i,
   output logic            pc_stall_o,
   input  logic            flush_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic            if_valid_o,
   output logic [XLEN-1:0] if_pc_o,
   output logic [XLEN-1:0] if_inst_o,
   input  logic            id_ready_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  ring [DEPTH];
   logic [AW-1:0] wp, fp, rp;
   logic [AW-1:0] gap;
   logic [CW-1:0] count, drop_cnt, unfilled;
   logic          alloc, pop;

   // rst gates the request so nothing leaks to imem while reset is held
   assign imem_req_o  = rst & pc_valid_i & ~flush_i & (count < CW'(DEPTH)) & (drop_cnt == '0);
   assign imem_addr_o = pc_i;
   assign alloc       = imem_req_o & imem_gnt_i;
   assign pc_stall_o  = ~rst | (pc_valid_i & ~alloc);

   assign if_valid_o  = (count != '0) & ring[rp].done;
   assign pop         = if_valid_o & id_ready_i;
   assign if_pc_o     = if_valid_o ? ring[rp].pc   : '0;
   assign if_inst_o   = if_valid_o ? ring[rp].inst : NOP_INST;

   // wp==fp is ambiguous when full: all-unfilled vs. all-filled, told apart by done
   assign gap = wp - fp;
   always_comb begin
      unfilled = {1'b0, gap};
      if ((gap == '0) && (count == CW'(DEPTH)) && !ring[fp].done)
         unfilled = CW'(DEPTH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp       <= '0;
         fp       <= '0;
         rp       <= '0;
         count    <= '0;
         drop_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      end else if (flush_i) begin
         fp       <= wp;
         rp       <= wp;
         count    <= '0;
         // any rvalid this cycle consumes one owed response, dropped or not
         drop_cnt <= drop_cnt + unfilled - {{AW{1'b0}}, imem_rvalid_i};
         for (int i = 0; i < DEPTH; i++) ring[i].done <= 1'b0;
      end else begin
         if (alloc) begin
            ring[wp].pc   <= pc_i;
            ring[wp].done <= 1'b0;
            wp            <= wp + AW'(1);
         end
         if (imem_rvalid_i) begin
            if (drop_cnt != '0) begin
               drop_cnt <= drop_cnt - CW'(1);
            end else begin
               ring[fp].inst <= imem_rdata_i;
               ring[fp].done <= 1'b1;
               fp            <= fp + AW'(1);
            end
         end
         if (pop) begin
            ring[rp].done <= 1'b0;
            rp            <= rp + AW'(1);
         end
         count <= count + CW'(alloc) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked each
// cycle against a queue-based model of the fetch buffer and imem.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_i = '0;
   logic        pc_valid_i = 1'b0, flush_i = 1'b0, imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0, id_ready_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic        pc_stall_o, imem_req_o, if_valid_o;
   logic [31:0] imem_addr_o, if_pc_o, if_inst_o;

   fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk(clk), .rst(rst_n), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_stall_o(pc_stall_o),
      .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
      .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .id_ready_i(id_ready_i)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] inst; bit done; } ment_t;
   ment_t       mq[$];      // allocated entries, oldest first
   logic [31:0] mem_q[$];   // addresses imem still owes a response for
   int          mdrop;
   int          checks = 0, errors = 0;
   bit          pend = 0;
   bit          d_pv, d_fl, d_gnt, d_rv, d_rdy, e_req, e_valid;
   logic [31:0] d_pc, d_rd;
   bit          ovr = 0;
   logic [31:0] ovr_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0F0F;
   endfunction

   task automatic update();
      if (d_fl) begin
         int nd = 0;
         foreach (mq[i]) if (!mq[i].done) nd++;
         mdrop = mdrop + nd - (d_rv ? 1 : 0);
         mq.delete();
      end else begin
         if (d_rv) begin
            if (mdrop > 0) mdrop--;
            else begin
               int k = 0;
               while (k < mq.size() && mq[k].done) k++;
               if (k < mq.size()) begin mq[k].inst = d_rd; mq[k].done = 1; end
            end
         end
         if (e_valid && d_rdy) void'(mq.pop_front());
         if (e_req && d_gnt) mq.push_back('{d_pc, 32'h0, 1'b0});
      end
      if (d_rv) void'(mem_q.pop_front());
      if (e_req && d_gnt) mem_q.push_back(d_pc);
   endtask

   // One clock: retire last cycle into the model, drive new inputs, compare all outputs.
   task automatic cyc(input bit pv, input logic [31:0] pc, input bit fl, input bit gnt,
                      input bit rv, input bit rdy);
      @(posedge clk);
      if (pend) update();
      @(negedge clk);
      d_pv = pv; d_pc = pc; d_fl = fl; d_gnt = gnt; d_rdy = rdy;
      d_rv = rv && (mem_q.size() > 0);
      d_rd = !d_rv ? 32'h0 : (ovr ? ovr_rd : mem_data(mem_q[0]));
      ovr = 0;
      pc_valid_i = pv; pc_i = pc; flush_i = fl; imem_gnt_i = gnt; id_ready_i = rdy;
      imem_rvalid_i = d_rv; imem_rdata_i = d_rd;
      e_req   = pv && !fl && (mq.size() < DEPTH) && (mdrop == 0);
      e_valid = (mq.size() > 0) && mq[0].done;
      #1;
      chk("imem_req", imem_req_o, e_req);
      chk("pc_stall", pc_stall_o, pv && !(e_req && gnt));
      chk("imem_addr", imem_addr_o, pc);
      chk("if_valid", if_valid_o, e_valid);
      chk("if_pc", if_pc_o, e_valid ? mq[0].pc : 32'h0);
      chk("if_inst", if_inst_o, e_valid ? mq[0].inst : NOP);
      pend = 1;
   endtask

   task automatic reset_checks();
      chk("rst_req", imem_req_o, 0);
      chk("rst_stall", pc_stall_o, 1);
      chk("rst_valid", if_valid_o, 0);
      chk("rst_pc", if_pc_o, 0);
      chk("rst_inst", if_inst_o, NOP);
   endtask

   task automatic do_reset();
      @(posedge clk);
      if (pend) update();
      pend = 0;
      #2;
      pc_valid_i = 1; pc_i = 32'h80; flush_i = 0; imem_gnt_i = 0;
      imem_rvalid_i = 0; id_ready_i = 0;
      #1 rst_n = 0;
      #1 reset_checks();
      mq.delete(); mem_q.delete(); mdrop = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
   endtask

   task automatic drain(output int n);
      n = 0;
      repeat (12) begin
         cyc(0, 32'h0, 0, 0, 1, 1);
         if (if_valid_o) n++;
      end
   endtask

   initial begin
      int n, k;
      logic [31:0] pcr;
      pc_valid_i = 1;
      #12 reset_checks();
      @(negedge clk) rst_n = 1;

      // first fetch: grant immediately, data two cycles later, visible one cycle after rvalid
      cyc(1, 32'h0, 0, 1, 0, 1);
      chk("t1_req", imem_req_o, 1);
      cyc(0, 32'h0, 0, 0, 0, 1);
      ovr = 1; ovr_rd = 32'hAAAA_0001;
      cyc(0, 32'h0, 0, 0, 1, 0);
      chk("t1_no_comb_path", if_valid_o, 0);
      cyc(0, 32'h0, 0, 0, 0, 1);
      chk("t1_valid", if_valid_o, 1);
      chk("t1_pc", if_pc_o, 32'h0);
      chk("t1_inst", if_inst_o, 32'hAAAA_0001);

      // streaming 0,4,8,C
      k = 0; n = 0;
      repeat (8) begin
         cyc(k < 4, 32'(4 * k), 0, 1, 1, 1);
         if (k < 4) chk("t2_stall", pc_stall_o, 0);
         if (if_valid_o) begin chk("t2_order", if_pc_o, 32'(4 * n)); n++; end
         if (e_req) k++;
      end
      chk("t2_count", n, 4);
      drain(n);

      // fill the ring with decode stalled
      k = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 32'(4 * k), 0, 1, 0, 0);
         if (i < 4) chk("t3_req", imem_req_o, 1);
         else begin chk("t3_full_req", imem_req_o, 0); chk("t3_full_stall", pc_stall_o, 1); end
         if (e_req) k++;
      end
      repeat (4) begin cyc(1, 32'h10, 0, 1, 1, 0); chk("t3_hold", pc_stall_o, 1); end
      cyc(1, 32'h10, 0, 1, 0, 1);
      chk("t3_pop", if_valid_o, 1);
      chk("t3_pop_req", imem_req_o, 0);
      cyc(1, 32'h10, 0, 1, 0, 0);
      chk("t3_resume", imem_req_o, 1);
      drain(n);
      chk("t3_drained", n, 4);

      // grant withheld three cycles
      repeat (3) begin
         cyc(1, 32'h20, 0, 0, 0, 0);
         chk("t4_stall", pc_stall_o, 1);
         chk("t4_addr", imem_addr_o, 32'h20);
      end
      cyc(1, 32'h20, 0, 1, 0, 0);
      chk("t4_gnt_stall", pc_stall_o, 0);
      drain(n);
      chk("t4_single", n, 1);

      // flush with two requests outstanding
      cyc(1, 32'h40, 0, 1, 0, 0);
      cyc(1, 32'h44, 0, 1, 0, 0);
      cyc(1, 32'h48, 1, 1, 0, 0);
      chk("t5_flush_req", imem_req_o, 0);
      cyc(1, 32'h100, 0, 1, 0, 0); chk("t5_wait0", imem_req_o, 0);
      cyc(1, 32'h100, 0, 1, 1, 0); chk("t5_wait1", imem_req_o, 0);
      cyc(1, 32'h100, 0, 1, 1, 0); chk("t5_wait2", imem_req_o, 0);
      chk("t5_no_stale", if_valid_o, 0);
      cyc(1, 32'h100, 0, 1, 0, 0); chk("t5_reissue", imem_req_o, 1);
      cyc(0, 32'h0, 0, 0, 1, 0);
      cyc(0, 32'h0, 0, 0, 0, 1);
      chk("t5_valid", if_valid_o, 1);
      chk("t5_pc", if_pc_o, 32'h100);

      // flush coincident with rvalid: only one response left to drop
      cyc(1, 32'h200, 0, 1, 0, 0);
      cyc(1, 32'h204, 0, 1, 0, 0);
      cyc(1, 32'h208, 1, 0, 1, 0);
      cyc(1, 32'h300, 0, 1, 0, 0); chk("t6_wait0", imem_req_o, 0);
      cyc(1, 32'h300, 0, 1, 1, 0); chk("t6_wait1", imem_req_o, 0);
      cyc(1, 32'h300, 0, 1, 0, 0); chk("t6_reissue", imem_req_o, 1);
      drain(n);

      // random traffic with an asynchronous reset in the middle
      pcr = 32'h1000;
      for (int i = 0; i < 3000; i++) begin
         bit pv, fl;
         if (i == 1500) begin do_reset(); pcr = 32'h2000; end
         pv = ($urandom % 4) != 0;
         fl = ($urandom % 20) == 0;
         cyc(pv, pcr, fl, ($urandom % 4) != 0, $urandom % 2, ($urandom % 3) != 0);
         if (e_req && d_gnt) pcr += 4;
         if (fl) pcr = $urandom & 32'hFFFF_FFFC;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
